// File: rtl/mbus_pkg.sv
// Shared definitions for the memory-bus interconnect: FSM states,
// index-width helper and wait-counter width.
package mbus_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ERR    = 2'd2
  } state_e;

  // Every wait count is a 4-bit value (0..15).
  localparam int CNT_W = 4;

  // Width of an index into n items; never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mbus_rr_arb.sv
// Combinational grant picker. In fixed mode the lowest eligible index wins.
// In round-robin mode the search starts one past the previous grant.
module mbus_rr_arb
  import mbus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ARB_MODE  = 0,
  parameter int IW        = idx_w(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] elig_i,
  input  logic [IW-1:0]        last_i,
  output logic [IW-1:0]        grant_o,
  output logic                 any_o
);

  // Walk the masters in priority order and take the first eligible one.
  always_comb begin
    int idx;
    idx     = 0;
    grant_o = '0;
    any_o   = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = (ARB_MODE == 1) ? ((int'(last_i) + 1 + k) % N_MASTERS) : k;
      for (int j = 0; j < N_MASTERS; j++) begin
        if (j == idx && !any_o && elig_i[j]) begin
          any_o   = 1'b1;
          grant_o = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mbus_interconnect.sv
// Memory-bus interconnect. It arbitrates N masters onto N_SLAVES
// address-decoded slaves. Each slave has its own programmable number of
// wait states. An access to an unmapped region completes with an error.
module mbus_interconnect
  import mbus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_LO    = 16,
  parameter int SEL_W     = 2,
  parameter int ARB_MODE  = 0,
  parameter logic [N_SLAVES*CNT_W-1:0] SLAVE_WAIT = {N_SLAVES{4'd1}}
) (
  input  logic                           clk,
  input  logic                           n_reset,
  input  logic [N_MASTERS-1:0]           m_en,
  input  logic [N_MASTERS-1:0]           m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]    m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]    m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0]  m_wstrb,
  output logic [N_MASTERS-1:0]           m_ready,
  output logic [N_MASTERS-1:0]           m_err,
  output logic [DATA_W-1:0]              m_rdata,
  output logic [N_SLAVES-1:0]            s_cs,
  output logic [ADDR_W-1:0]              s_adr,
  output logic [DATA_W-1:0]              s_di,
  output logic [DATA_W/8-1:0]            s_wren,
  input  logic [N_SLAVES*DATA_W-1:0]     s_do
);

  localparam int IW = idx_w(N_MASTERS);
  localparam int SB = DATA_W / 8;

  state_e           state_q;
  logic [IW-1:0]    g_q, last_q;
  logic [SEL_W-1:0] r_q;
  logic [CNT_W-1:0] cnt_q;

  logic [IW-1:0]    g_d;
  logic             any_d;
  logic [SEL_W-1:0] r_d;
  logic [CNT_W-1:0] cnt_d;
  logic             mapped_d;

  mbus_rr_arb #(
    .N_MASTERS(N_MASTERS),
    .ARB_MODE (ARB_MODE),
    .IW       (IW)
  ) u_arb (
    .elig_i (m_valid & m_en),
    .last_i (last_q),
    .grant_o(g_d),
    .any_o  (any_d)
  );

  // Decode the winning master's region and look up the region's wait count.
  always_comb begin
    r_d   = '0;
    cnt_d = '0;
    for (int m = 0; m < N_MASTERS; m++)
      if (int'(g_d) == m) r_d = m_addr[m*ADDR_W+SEL_LO +: SEL_W];
    mapped_d = (int'(r_d) < N_SLAVES);
    for (int s = 0; s < N_SLAVES; s++)
      if (mapped_d && int'(r_d) == s) cnt_d = SLAVE_WAIT[s*CNT_W +: CNT_W];
  end

  // Transaction FSM. The grant, region and wait count are latched in IDLE
  // and held until the completion cycle.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      last_q  <= IW'(N_MASTERS - 1);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_d) begin
            g_q     <= g_d;
            last_q  <= g_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            state_q <= mapped_d ? S_ACCESS : S_ERR;
          end
        end
        S_ACCESS: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
          else             state_q <= S_IDLE;
        end
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Route the granted master to the slave bus and return the completion.
  // The routing ignores the live valid/enable so that a started access
  // always finishes.
  always_comb begin
    s_cs    = '0;
    s_wren  = '0;
    m_ready = '0;
    m_err   = '0;
    m_rdata = '0;
    s_adr   = m_addr[ADDR_W-1:0];
    s_di    = m_wdata[DATA_W-1:0];
    for (int m = 0; m < N_MASTERS; m++) begin
      if (int'(g_q) == m && state_q != S_IDLE) begin
        s_adr = m_addr[m*ADDR_W +: ADDR_W];
        s_di  = m_wdata[m*DATA_W +: DATA_W];
        if (state_q == S_ACCESS) begin
          s_wren = m_wstrb[m*SB +: SB];
          if (cnt_q == '0) m_ready[m] = 1'b1;
        end else if (state_q == S_ERR) begin
          m_ready[m] = 1'b1;
          m_err[m]   = 1'b1;
        end
      end
    end
    for (int s = 0; s < N_SLAVES; s++) begin
      if (state_q == S_ACCESS && int'(r_q) == s) begin
        s_cs[s] = 1'b1;
        if (cnt_q == '0) m_rdata = s_do[s*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_mbus_interconnect.sv
// Directed bench for mbus_interconnect. Two instances share the same stimulus:
// - dut_a uses fixed priority with waits slave0=4, slave1=3, slave2=1;
// - dut_b uses round-robin with the default waits.
module tb_mbus_interconnect;

  logic        clk, n_reset;
  logic [1:0]  m_en, m_valid;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wstrb;
  logic [95:0] s_do;

  logic [1:0]  a_m_ready, a_m_err, b_m_ready, b_m_err;
  logic [31:0] a_m_rdata, b_m_rdata, a_s_adr, b_s_adr, a_s_di, b_s_di;
  logic [2:0]  a_s_cs, b_s_cs;
  logic [3:0]  a_s_wren, b_s_wren;

  int checks = 0;
  int errors = 0;

  mbus_interconnect #(.ARB_MODE(0), .SLAVE_WAIT(12'h134)) dut_a (
    .clk(clk), .n_reset(n_reset), .m_en(m_en), .m_valid(m_valid),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(a_m_ready), .m_err(a_m_err), .m_rdata(a_m_rdata),
    .s_cs(a_s_cs), .s_adr(a_s_adr), .s_di(a_s_di), .s_wren(a_s_wren),
    .s_do(s_do)
  );

  mbus_interconnect #(.ARB_MODE(1)) dut_b (
    .clk(clk), .n_reset(n_reset), .m_en(m_en), .m_valid(m_valid),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(b_m_ready), .m_err(b_m_err), .m_rdata(b_m_rdata),
    .s_cs(b_s_cs), .s_adr(b_s_adr), .s_di(b_s_di), .s_wren(b_s_wren),
    .s_do(s_do)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    m_addr[m*32 +: 32]  = a;
    m_wdata[m*32 +: 32] = d;
    m_wstrb[m*4 +: 4]   = st;
    m_valid[m]          = 1'b1;
  endtask

  initial begin
    logic [1:0] ga [6];
    logic [1:0] gb [6];
    int na, nb, k;

    clk = 0; n_reset = 0; m_en = 2'b11; m_valid = 0;
    m_addr = 0; m_wdata = 0; m_wstrb = 0;
    s_do = {32'h2222_2222, 32'h1111_1111, 32'hA0A0_0000};

    // Outputs while reset is asserted
    #2;
    chk("rst_cs", a_s_cs, 3'b000);
    chk("rst_ready", a_m_ready, 2'b00);
    chk("rst_err", a_m_err, 2'b00);
    chk("rst_rdata", a_m_rdata, 32'h0);
    chk("rst_wren", a_s_wren, 4'h0);
    step; step;
    n_reset = 1;
    step;

    // Single read: master 1 reads slave 2, which has one wait state
    req(1, 32'h0002_0004, 32'h0, 4'h0);
    step;
    chk("t1_cs_a", a_s_cs, 3'b100);
    chk("t1_rdy_a", a_m_ready, 2'b00);
    chk("t1_adr", a_s_adr, 32'h0002_0004);
    step;
    chk("t1_cs_b", a_s_cs, 3'b100);
    chk("t1_rdy_b", a_m_ready, 2'b10);
    chk("t1_rdata", a_m_rdata, 32'h2222_2222);
    m_valid = 0;
    step;
    chk("t1_cs_end", a_s_cs, 3'b000);
    chk("t1_rdy_end", a_m_ready, 2'b00);
    step; step; step;

    // Write with four wait states on slave 0
    req(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    for (int i = 1; i <= 5; i++) begin
      step;
      chk("t2_cs", a_s_cs, 3'b001);
      chk("t2_wren", a_s_wren, 4'hF);
      chk("t2_rdy", a_m_ready, (i == 5) ? 2'b01 : 2'b00);
      if (i == 1) chk("t2_di", a_s_di, 32'hDEAD_BEEF);
    end
    m_valid = 0; m_wstrb = 0;
    step;
    chk("t2_cs_end", a_s_cs, 3'b000);
    chk("t2_wren_end", a_s_wren, 4'h0);
    step; step; step;

    // Unmapped region 3
    req(0, 32'h0003_0000, 32'h0, 4'h0);
    step;
    chk("t3_rdy", a_m_ready, 2'b01);
    chk("t3_err", a_m_err, 2'b01);
    chk("t3_rdata", a_m_rdata, 32'h0);
    chk("t3_cs", a_s_cs, 3'b000);
    m_valid = 0;
    step;
    chk("t3_rdy_end", a_m_ready, 2'b00);
    chk("t3_err_end", a_m_err, 2'b00);
    step; step; step;

    // Contention from a fresh reset: both masters request slave 2 continuously
    n_reset = 0; #1; n_reset = 1;
    req(0, 32'h0002_0000, 32'h0, 4'h0);
    req(1, 32'h0002_0008, 32'h0, 4'h0);
    na = 0; nb = 0;
    for (int c = 0; c < 40 && (na < 6 || nb < 6); c++) begin
      step;
      if (a_m_ready != 2'b00 && na < 6) begin ga[na] = a_m_ready; na++; end
      if (b_m_ready != 2'b00 && nb < 6) begin gb[nb] = b_m_ready; nb++; end
    end
    chk("t4_count_fixed", na, 6);
    chk("t4_count_rr", nb, 6);
    for (int i = 0; i < 6; i++) begin
      if (i < na) chk("t4_fixed_grant", ga[i], 2'b01);
      if (i < nb) chk("t4_rr_grant", gb[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    m_valid = 0;
    step; step; step;

    // Enable gating: a disabled master is never granted
    m_en = 2'b01;
    req(1, 32'h0002_0000, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      step;
      chk("t5_gated_rdy", a_m_ready, 2'b00);
      chk("t5_gated_cs", a_s_cs, 3'b000);
    end
    // Dropping the enable mid-access still completes the transaction
    m_valid = 0; m_en = 2'b11;
    req(0, 32'h0000_0010, 32'h0, 4'h0);
    step;
    chk("t5_cs", a_s_cs, 3'b001);
    m_en = 2'b10;
    k = 0;
    do begin step; k++; end while (a_m_ready == 2'b00 && k < 10);
    chk("t5_lat", k, 4);
    chk("t5_rdy", a_m_ready, 2'b01);
    chk("t5_rdata", a_m_rdata, 32'hA0A0_0000);
    m_valid = 0; m_en = 2'b11;
    step; step; step;

    // Asynchronous reset in the middle of a three-wait access to slave 1
    req(0, 32'h0001_0000, 32'h1234_5678, 4'hF);
    step;
    chk("t6_cs", a_s_cs, 3'b010);
    step;
    n_reset = 0;
    #1;
    chk("t6_rst_cs", a_s_cs, 3'b000);
    chk("t6_rst_rdy", a_m_ready, 2'b00);
    chk("t6_rst_wren", a_s_wren, 4'h0);
    chk("t6_rst_err", a_m_err, 2'b00);
    m_valid = 0; m_wstrb = 0;
    step;
    n_reset = 1;
    step;
    req(0, 32'h0001_0000, 32'h0, 4'h0);
    k = 0;
    do begin step; k++; end while (a_m_ready == 2'b00 && k < 10);
    chk("t6_lat", k, 4);
    chk("t6_rdy", a_m_ready, 2'b01);
    chk("t6_rdata", a_m_rdata, 32'h1111_1111);
    m_valid = 0;
    step;
    chk("t6_rdy_end", a_m_ready, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
